// File: rtl/pid_plant_model.sv
// First-order-lag plant emulator with gain, whole-sample transport delay and output saturation.
// Optional output noise from a 16-bit LFSR is compiled in when PLANT_NOISE_EN is defined.
module pid_plant_model #(
  parameter int                 GAIN   = 1,
  parameter int                 SHIFT  = 2,
  parameter int                 DELAY  = 0,
  parameter int                 DIV    = 4,
  parameter logic signed [15:0] Y_INIT = 16'sh0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] u_in,
  input  logic        u_valid,
  output logic [15:0] y_out,
  output logic        y_valid,
  output logic        sat_flag,
  output logic        busy
);

  localparam int CW   = $clog2(DIV);
  localparam int DL_N = (DELAY == 0) ? 1 : DELAY;
  localparam logic signed [31:0] GAIN_C = 32'(GAIN);

  typedef enum logic [1:0] {IDLE, SHIFT_IN, COMPUTE, UPDATE} state_t;

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic [15:0]        u_lat_r;
  logic [15:0]        samp_r;
  logic [15:0]        u_d_r;
  logic [15:0]        dl_r [DL_N];
  logic               tick_s;
  logic signed [31:0] prod_s;
  logic [15:0]        target_s;
  logic signed [16:0] diff_s;
  logic signed [16:0] step_s;
  logic signed [17:0] sum_s;
  logic [15:0]        y_next_s;
  logic               sat_evt_s;
`ifdef PLANT_NOISE_EN
  logic [15:0]        lfsr_r;
`endif

  function automatic logic ovf32(input logic signed [31:0] v);
    return (v > 32'sd32767) || (v < -32'sd32768);
  endfunction

  function automatic logic [15:0] sat32(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'h7FFF;
    else if (v < -32'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

  function automatic logic ovf18(input logic signed [17:0] v);
    return (v > 18'sd32767) || (v < -18'sd32768);
  endfunction

  function automatic logic [15:0] sat18(input logic signed [17:0] v);
    if (v > 18'sd32767)       return 16'h7FFF;
    else if (v < -18'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

  assign tick_s = en && (cnt_r == CW'(DIV - 1));

  // Lag update datapath: clamped gain target, shifted error, clamped accumulate.
  always_comb begin
    prod_s   = GAIN_C * $signed({{16{u_d_r[15]}}, u_d_r});
    target_s = sat32(prod_s);
    diff_s   = $signed({target_s[15], target_s}) - $signed({y_out[15], y_out});
    step_s   = diff_s >>> SHIFT;
    sum_s    = $signed({y_out[15], y_out[15], y_out}) + $signed({step_s[16], step_s});
`ifdef PLANT_NOISE_EN
    sum_s    = sum_s + $signed({{15{lfsr_r[2]}}, lfsr_r[2:0]});
`endif
    y_next_s  = sat18(sum_s);
    sat_evt_s = ovf32(prod_s) || ovf18(sum_s);
  end

  // Sample counter, input latch, delay line and the update sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      u_lat_r  <= 16'h0000;
      samp_r   <= 16'h0000;
      u_d_r    <= 16'h0000;
      for (int i = 0; i < DL_N; i++) dl_r[i] <= 16'h0000;
      y_out    <= Y_INIT;
      y_valid  <= 1'b0;
      sat_flag <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (u_valid) u_lat_r <= u_in;
      if (en) cnt_r <= (cnt_r == CW'(DIV - 1)) ? '0 : cnt_r + CW'(1);
      y_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tick_s) begin
            samp_r  <= u_valid ? u_in : u_lat_r;
            state_r <= SHIFT_IN;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        SHIFT_IN: begin
          if (DELAY == 0) begin
            u_d_r <= samp_r;
          end else begin
            u_d_r <= dl_r[DL_N-1];
            for (int i = DL_N - 1; i > 0; i--) dl_r[i] <= dl_r[i-1];
            dl_r[0] <= samp_r;
          end
          state_r <= COMPUTE;
        end
        COMPUTE: begin
          // y_out is loaded here so that it is already valid during UPDATE.
          y_out   <= y_next_s;
          y_valid <= 1'b1;
          if (sat_evt_s) sat_flag <= 1'b1;
          state_r <= UPDATE;
        end
        UPDATE: begin
          if (tick_s) begin
            samp_r  <= u_valid ? u_in : u_lat_r;
            state_r <= SHIFT_IN;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLANT_NOISE_EN
  // Noise source: Fibonacci LFSR x^16+x^14+x^13+x^11+1, one step per output update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_r <= 16'hACE1;
    end else if (state_r == UPDATE) begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end
`endif

endmodule
